// File: rtl/dk_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dk_sound_sequencer
// Brief    : Sample-strobe divider plus four independent trigger-to-pulse
//            sequencers (IDLE -> ACTIVE -> HOLDOFF) that gate the discrete
//            sound datapaths.
// Options  : define DK_SEQ_RETRIGGER_EN to let a fresh trigger edge during
//            ACTIVE reload the pulse length instead of being ignored.
// Revision : 1.0 - initial release
// ============================================================================
module dk_sound_sequencer #(
    parameter int          CLOCK_RATE    = 192000,
    parameter int          SAMPLE_RATE   = 96000,
    parameter logic [63:0] PULSE_SAMPLES = {16'd2800, 16'd1400, 16'd1400, 16'd2800},
    parameter logic [15:0] GAP_SAMPLES   = 16'd8
) (
    input  logic       clk,
    input  logic       I_RSTn,
    input  logic [3:0] trig,
    output logic       audio_clk_en,
    output logic [3:0] sound_en,
    output logic [3:0] busy
);

    localparam int DIV   = CLOCK_RATE / SAMPLE_RATE;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_HOLDOFF = 2'd2;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             strobe_q;
    logic [3:0]       trig_q;
    logic [3:0]       edge_w;
    logic [3:0]       retrig_w;

    // Free-running divider: wraps at DIV-1, independent of channel activity.
    always_comb begin
        div_d = (div_q == C_DIV_LAST) ? '0 : div_q + 1'b1;
    end

    // Divider count and registered strobe; the strobe is registered so it is
    // low in reset and first appears DIV clocks after release.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            div_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            strobe_q <= (div_q == C_DIV_LAST);
        end
    end

    assign audio_clk_en = strobe_q;

    // Previous trigger level for rising-edge detection; cleared in reset so a
    // trigger already high at release counts as an edge.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            trig_q <= 4'b0000;
        end else begin
            trig_q <= trig;
        end
    end

    assign edge_w = trig & ~trig_q;

`ifdef DK_SEQ_RETRIGGER_EN
    assign retrig_w = edge_w;
`else
    assign retrig_w = 4'b0000;
`endif

    genvar ch;
    generate
        for (ch = 0; ch < 4; ch++) begin : g_ch
            // A zero pulse length still produces a one-sample pulse.
            localparam logic [15:0] C_LOAD =
                (PULSE_SAMPLES[ch*16 +: 16] == 16'd0) ? 16'd1 : PULSE_SAMPLES[ch*16 +: 16];

            logic [1:0]  state_q;
            logic [1:0]  state_d;
            logic [15:0] cnt_q;
            logic [15:0] cnt_d;

            // Next-state logic: counters only move on sample strobes; a
            // retrigger edge (when enabled) outranks expiry in ACTIVE.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    S_IDLE: begin
                        if (edge_w[ch]) begin
                            state_d = S_ACTIVE;
                            cnt_d   = C_LOAD;
                        end
                    end
                    S_ACTIVE: begin
                        if (retrig_w[ch]) begin
                            cnt_d = C_LOAD;
                        end else if (strobe_q) begin
                            if (cnt_q == 16'd1) begin
                                if (GAP_SAMPLES == 16'd0) begin
                                    state_d = S_IDLE;
                                    cnt_d   = 16'd0;
                                end else begin
                                    state_d = S_HOLDOFF;
                                    cnt_d   = GAP_SAMPLES;
                                end
                            end else begin
                                cnt_d = cnt_q - 16'd1;
                            end
                        end
                    end
                    S_HOLDOFF: begin
                        if (strobe_q) begin
                            if (cnt_q == 16'd1) begin
                                state_d = S_IDLE;
                                cnt_d   = 16'd0;
                            end else begin
                                cnt_d = cnt_q - 16'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = 16'd0;
                    end
                endcase
            end

            // Channel state and counter registers.
            always_ff @(posedge clk or negedge I_RSTn) begin
                if (!I_RSTn) begin
                    state_q <= S_IDLE;
                    cnt_q   <= 16'd0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign sound_en[ch] = (state_q == S_ACTIVE);
            assign busy[ch]     = (state_q != S_IDLE);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dk_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dk_sound_sequencer
// Brief    : Directed self-checking bench for dk_sound_sequencer with a
//            per-channel "strobes remaining" reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dk_sound_sequencer;

    localparam int          DIV   = 2;
    localparam logic [63:0] PULSE = {16'd0, 16'd6, 16'd4, 16'd4};
    localparam int          GAP   = 2;
    // Effective pulse lengths by channel (a zero length behaves as one).
    localparam int          P_LEN [4] = '{4, 4, 6, 1};
`ifdef DK_SEQ_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] trig  = 4'b0000;
    logic       audio_clk_en;
    logic [3:0] sound_en;
    logic [3:0] busy;

    int vectors    = 0;
    int miscompares = 0;
    int ec [4];
    int bc [4];

    // Reference model state
    int         m_k;
    logic       m_strobe;
    logic       m_s;
    logic       m_e;
    logic [3:0] m_trig_q;
    int         m_en_left [4];
    int         m_hold_left [4];

    always #5 clk = ~clk;

    dk_sound_sequencer #(
        .CLOCK_RATE   (4),
        .SAMPLE_RATE  (2),
        .PULSE_SAMPLES(PULSE),
        .GAP_SAMPLES  (16'(GAP))
    ) u_dut (
        .clk         (clk),
        .I_RSTn      (rst_n),
        .trig        (trig),
        .audio_clk_en(audio_clk_en),
        .sound_en    (sound_en),
        .busy        (busy)
    );

    // Model: strobe every DIV-th clock after release; each channel holds a
    // number of enabled strobes left, then a number of holdoff strobes left.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k      = 0;
            m_strobe = 1'b0;
            m_trig_q = 4'b0000;
            for (int c = 0; c < 4; c++) begin
                m_en_left[c]   = 0;
                m_hold_left[c] = 0;
            end
        end else begin
            m_s = m_strobe;
            for (int c = 0; c < 4; c++) begin
                m_e = trig[c] && !m_trig_q[c];
                if (m_en_left[c] > 0) begin
                    if (RETRIG && m_e) begin
                        m_en_left[c] = P_LEN[c];
                    end else if (m_s) begin
                        m_en_left[c] = m_en_left[c] - 1;
                        if (m_en_left[c] == 0) m_hold_left[c] = GAP;
                    end
                end else if (m_hold_left[c] > 0) begin
                    if (m_s) m_hold_left[c] = m_hold_left[c] - 1;
                end else if (m_e) begin
                    m_en_left[c] = P_LEN[c];
                end
            end
            m_trig_q = trig;
            m_k      = m_k + 1;
            m_strobe = ((m_k % DIV) == 0);
        end
    end

    // Advance to the next falling edge, compare against the model, and tally
    // strobes seen while each channel is enabled / busy.
    task automatic step();
        logic [3:0] xs;
        logic [3:0] xb;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            xs[c] = (m_en_left[c] > 0);
            xb[c] = (m_en_left[c] > 0) || (m_hold_left[c] > 0);
        end
        vectors++;
        if ({audio_clk_en, sound_en, busy} !== {m_strobe, xs, xb}) begin
            miscompares++;
            $display("FAIL cycle t=%0t en/sound/busy got %b/%b/%b want %b/%b/%b",
                     $time, audio_clk_en, sound_en, busy, m_strobe, xs, xb);
        end
        for (int c = 0; c < 4; c++) begin
            ec[c] += int'(audio_clk_en & sound_en[c]);
            bc[c] += int'(audio_clk_en & busy[c]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) begin
            ec[c] = 0;
            bc[c] = 0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy != 4'b0000 && n < 200) begin
            step();
            n++;
        end
        if (busy != 4'b0000) chk({name, "_idle_timeout"}, int'(busy), 0);
    endtask

    task automatic pulse(input logic [3:0] bits);
        trig = trig | bits;
        step();
        trig = trig & ~bits;
    endtask

    initial begin
        int n;
        clear_counts();

        // Reset state
        repeat (3) step();
        chk("reset_outputs", int'({audio_clk_en, sound_en, busy}), 0);
        rst_n = 1'b1;

        // Free run, no triggers: 5 strobes in 10 clocks
        clear_counts();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n += int'(audio_clk_en);
        end
        chk("freerun_strobes", n, 5);
        chk("freerun_busy", int'(busy), 0);

        // Single pulse on channel 0
        clear_counts();
        pulse(4'b0001);
        wait_idle("single");
        chk("single_en_strobes", ec[0], 4);
        chk("single_busy_strobes", bc[0], 6);

        // Re-edge during HOLDOFF is dropped, after IDLE it fires
        pulse(4'b0001);
        n = 0;
        while (!(busy[0] && !sound_en[0]) && n < 100) begin
            step();
            n++;
        end
        chk("reach_holdoff", int'(busy[0] && !sound_en[0]), 1);
        clear_counts();
        pulse(4'b0001);
        wait_idle("holdoff");
        chk("holdoff_edge_ignored", ec[0], 0);
        clear_counts();
        pulse(4'b0001);
        wait_idle("after_idle");
        chk("after_idle_pulse", ec[0], 4);

        // Held-high trigger does not retrigger
        clear_counts();
        trig[0] = 1'b1;
        repeat (30) step();
        trig[0] = 1'b0;
        wait_idle("held");
        chk("held_high_once", ec[0], 4);

        // Toggling trigger every clock: edges land in every state
        for (int i = 0; i < 40; i++) begin
            trig[0] = ~trig[0];
            step();
        end
        trig[0] = 1'b0;
        wait_idle("toggle");

        // Re-edge on channel 1 at its third strobe
        clear_counts();
        pulse(4'b0010);
        n = 0;
        while (ec[1] < 3 && n < 100) begin
            step();
            n++;
        end
        pulse(4'b0010);
        wait_idle("retrig");
        chk("retrig_en_strobes", ec[1], RETRIG ? 7 : 4);

        // Async reset mid-pulse; trig[2] held high across release
        clear_counts();
        pulse(4'b0001);
        n = 0;
        while (ec[0] < 2 && n < 100) begin
            step();
            n++;
        end
        trig = 4'b0100;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_sound_en", int'(sound_en), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_strobe", int'(audio_clk_en), 0);
        repeat (3) step();
        rst_n = 1'b1;
        clear_counts();
        step();
        chk("edge_at_release", int'(sound_en), 4'b0100);
        n = 1;
        while (!audio_clk_en && n < 10) begin
            step();
            n++;
        end
        chk("first_strobe_after_release", n, DIV);
        trig = 4'b0000;
        wait_idle("release");
        chk("release_ch2_strobes", ec[2], 6);

        // All four channels triggered together
        clear_counts();
        trig = 4'b1111;
        step();
        chk("all_rise_together", int'(sound_en), 4'b1111);
        trig = 4'b0000;
        wait_idle("all");
        chk("all_ch0_strobes", ec[0], 4);
        chk("all_ch1_strobes", ec[1], 4);
        chk("all_ch2_strobes", ec[2], 6);
        chk("all_ch3_strobes", ec[3], 1);

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
